// File: rtl/processor_pkg.sv
// Shared opcode constants, controller state encodings and instruction layout
// for the multi-cycle processor.
package processor_pkg;

   localparam logic [2:0] FETCH     = 3'd0;
   localparam logic [2:0] DECODE    = 3'd1;
   localparam logic [2:0] EXECUTE   = 3'd2;
   localparam logic [2:0] WRITEBACK = 3'd3;
   localparam logic [2:0] HALT      = 3'd4;

   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_LI   = 6'd10;
   localparam logic [5:0] OP_ADDI = 6'd11;
   localparam logic [5:0] OP_SUBI = 6'd12;
   localparam logic [5:0] OP_SW   = 6'd20;
   localparam logic [5:0] OP_HALT = 6'd63;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [15:0] imm;
   } instr_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

endpackage

// File: rtl/processor_ctrl.sv
// Multi-cycle controller: FETCH/DECODE/EXECUTE/WRITEBACK/HALT sequencing,
// operand and result registers, and the store port.
module processor_ctrl
   import processor_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic [31:0] rd_a,
   input  logic [31:0] rd_b,
   output logic [4:0]  rs_a,
   output logic [4:0]  rs_b,
   output logic        wr_en,
   output logic [4:0]  wr_sel,
   output logic [31:0] wr_data,
   output logic [31:0] addr,
   output logic [31:0] out,
   output logic        rw,
   output logic        sys_dne
);

   logic [2:0]  state;
   instr_t      ir;
   logic [31:0] a, b, result;
   logic [31:0] addr_q, out_q;
   logic [31:0] imm_ext;
   logic        store_now;

   assign imm_ext = sext16(ir.imm);
   assign rs_a    = ir.ra;
   assign rs_b    = ir.rb;

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= FETCH;
         ir     <= '0;
         a      <= '0;
         b      <= '0;
         result <= '0;
         addr_q <= '0;
         out_q  <= '0;
      end else begin
         case (state)
            FETCH: begin
               ir    <= instruction;
               state <= DECODE;
            end
            DECODE: begin
               a <= rd_a;
               b <= rd_b;
               case (ir.op)
                  OP_ADD, OP_SUB, OP_ADDI, OP_SUBI, OP_SW: state <= EXECUTE;
                  OP_HALT:                                 state <= HALT;
                  default:                                 state <= FETCH;
               endcase
            end
            EXECUTE: begin
               case (ir.op)
                  OP_ADDI: result <= a + imm_ext;
                  OP_SUBI: result <= a - imm_ext;
                  OP_ADD:  result <= a + b;
                  OP_SUB:  result <= a - b;
                  default: begin
                     addr_q <= a + imm_ext;
                     out_q  <= b;
                  end
               endcase
               state <= (ir.op == OP_SW) ? FETCH : WRITEBACK;
            end
            WRITEBACK: state <= FETCH;
            HALT:      state <= HALT;
            default:   state <= FETCH;
         endcase
      end
   end

   // NOTE: every always_comb output gets a default first, so no latch is inferred.
   always_comb begin
      wr_en   = 1'b0;
      wr_sel  = ir.ra;
      wr_data = imm_ext;
      if (state == DECODE && ir.op == OP_LI) begin
         wr_en = 1'b1;
      end else if (state == WRITEBACK) begin
         wr_en   = 1'b1;
         wr_data = result;
         wr_sel  = (ir.op == OP_ADDI || ir.op == OP_SUBI) ? ir.rb : ir.imm[4:0];
      end
   end

   // The store is visible during EXECUTE itself; the held copies cover idle cycles.
   assign store_now = (state == EXECUTE) && (ir.op == OP_SW) && !reset;
   assign rw        = store_now;
   assign addr      = reset ? '0 : (store_now ? a + imm_ext : addr_q);
   assign out       = reset ? '0 : (store_now ? b : out_q);
   assign sys_dne   = (state == HALT) && !reset;

endmodule

// File: rtl/processor_reg32.sv
// One 32-bit architectural register with synchronous clear and write enable.
module reg32 (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] d,
   output logic [31:0] q
);

   logic [31:0] internal;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset)
         internal <= '0;
      else if (we)
         internal <= d;
   end

   assign q = internal;

endmodule

// File: rtl/processor.sv
// Top level: 32-entry register file built from reg32 instances, driven by
// the multi-cycle controller c.
module processor
   import processor_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   output logic [31:0] addr,
   output logic [31:0] out,
   output logic        rw,
   output logic        sys_dne
);

   logic [31:0] rq [32];
   logic [31:0] we;
   logic [4:0]  rs_a, rs_b, wr_sel;
   logic        wr_en;
   logic [31:0] wr_data, rd_a, rd_b;

   // Bit 0 is never enabled, which discards writes to R0.
   assign we   = wr_en ? ((32'd1 << wr_sel) & ~32'd1) : 32'd0;
   assign rd_a = (rs_a == 5'd0) ? 32'd0 : rq[rs_a];
   assign rd_b = (rs_b == 5'd0) ? 32'd0 : rq[rs_b];

   processor_ctrl c (
      .clk(clk), .reset(reset), .instruction(instruction),
      .rd_a(rd_a), .rd_b(rd_b), .rs_a(rs_a), .rs_b(rs_b),
      .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .addr(addr), .out(out), .rw(rw), .sys_dne(sys_dne)
   );

   reg32 r0  (.clk(clk), .reset(reset), .we(we[0]),  .d(wr_data), .q(rq[0]));
   reg32 r1  (.clk(clk), .reset(reset), .we(we[1]),  .d(wr_data), .q(rq[1]));
   reg32 r2  (.clk(clk), .reset(reset), .we(we[2]),  .d(wr_data), .q(rq[2]));
   reg32 r3  (.clk(clk), .reset(reset), .we(we[3]),  .d(wr_data), .q(rq[3]));
   reg32 r4  (.clk(clk), .reset(reset), .we(we[4]),  .d(wr_data), .q(rq[4]));
   reg32 r5  (.clk(clk), .reset(reset), .we(we[5]),  .d(wr_data), .q(rq[5]));
   reg32 r6  (.clk(clk), .reset(reset), .we(we[6]),  .d(wr_data), .q(rq[6]));
   reg32 r7  (.clk(clk), .reset(reset), .we(we[7]),  .d(wr_data), .q(rq[7]));
   reg32 r8  (.clk(clk), .reset(reset), .we(we[8]),  .d(wr_data), .q(rq[8]));
   reg32 r9  (.clk(clk), .reset(reset), .we(we[9]),  .d(wr_data), .q(rq[9]));
   reg32 r10 (.clk(clk), .reset(reset), .we(we[10]), .d(wr_data), .q(rq[10]));
   reg32 r11 (.clk(clk), .reset(reset), .we(we[11]), .d(wr_data), .q(rq[11]));
   reg32 r12 (.clk(clk), .reset(reset), .we(we[12]), .d(wr_data), .q(rq[12]));
   reg32 r13 (.clk(clk), .reset(reset), .we(we[13]), .d(wr_data), .q(rq[13]));
   reg32 r14 (.clk(clk), .reset(reset), .we(we[14]), .d(wr_data), .q(rq[14]));
   reg32 r15 (.clk(clk), .reset(reset), .we(we[15]), .d(wr_data), .q(rq[15]));
   reg32 r16 (.clk(clk), .reset(reset), .we(we[16]), .d(wr_data), .q(rq[16]));
   reg32 r17 (.clk(clk), .reset(reset), .we(we[17]), .d(wr_data), .q(rq[17]));
   reg32 r18 (.clk(clk), .reset(reset), .we(we[18]), .d(wr_data), .q(rq[18]));
   reg32 r19 (.clk(clk), .reset(reset), .we(we[19]), .d(wr_data), .q(rq[19]));
   reg32 r20 (.clk(clk), .reset(reset), .we(we[20]), .d(wr_data), .q(rq[20]));
   reg32 r21 (.clk(clk), .reset(reset), .we(we[21]), .d(wr_data), .q(rq[21]));
   reg32 r22 (.clk(clk), .reset(reset), .we(we[22]), .d(wr_data), .q(rq[22]));
   reg32 r23 (.clk(clk), .reset(reset), .we(we[23]), .d(wr_data), .q(rq[23]));
   reg32 r24 (.clk(clk), .reset(reset), .we(we[24]), .d(wr_data), .q(rq[24]));
   reg32 r25 (.clk(clk), .reset(reset), .we(we[25]), .d(wr_data), .q(rq[25]));
   reg32 r26 (.clk(clk), .reset(reset), .we(we[26]), .d(wr_data), .q(rq[26]));
   reg32 r27 (.clk(clk), .reset(reset), .we(we[27]), .d(wr_data), .q(rq[27]));
   reg32 r28 (.clk(clk), .reset(reset), .we(we[28]), .d(wr_data), .q(rq[28]));
   reg32 r29 (.clk(clk), .reset(reset), .we(we[29]), .d(wr_data), .q(rq[29]));
   reg32 r30 (.clk(clk), .reset(reset), .we(we[30]), .d(wr_data), .q(rq[30]));
   reg32 r31 (.clk(clk), .reset(reset), .we(we[31]), .d(wr_data), .q(rq[31]));

endmodule

// File: tb/tb_processor.sv
// Bench for processor: directed scenarios plus random instruction streams,
// checked against an instruction-level model of the architectural state.
module tb_processor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instruction = 32'd0;
   logic [31:0] addr, out;
   logic        rw, sys_dne;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_reg [32];
   logic [31:0] m_addr, m_out;

   processor dut (
      .clk(clk), .reset(reset), .instruction(instruction),
      .addr(addr), .out(out), .rw(rw), .sys_dne(sys_dne)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word(input int op, input int ra, input int rb, input int imm);
      logic [5:0]  o = 6'(op);
      logic [4:0]  a = 5'(ra);
      logic [4:0]  b = 5'(rb);
      logic [15:0] i = 16'(imm);
      return {o, a, b, i};
   endfunction

   task automatic do_reset;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
      m_addr = 32'd0;
      m_out  = 32'd0;
   endtask

   // Execute one instruction on the model, then clock the DUT for the
   // instruction's architectural cycle count and compare the store port.
   task automatic run(input logic [31:0] w);
      int          op, ra, rb, cycles, dst;
      logic [31:0] imm, va, vb, val, sa, so;
      logic        store, wr;
      op  = int'(w[31:26]);
      ra  = int'(w[25:21]);
      rb  = int'(w[20:16]);
      imm = 32'($signed(w[15:0]));
      va  = (ra == 0) ? 32'd0 : m_reg[ra];
      vb  = (rb == 0) ? 32'd0 : m_reg[rb];
      store = 1'b0; wr = 1'b0; dst = 0; val = 0; sa = 0; so = 0;
      case (op)
         10: begin cycles = 2; wr = 1'b1; dst = ra; val = imm; end
         11: begin cycles = 4; wr = 1'b1; dst = rb; val = va + imm; end
         12: begin cycles = 4; wr = 1'b1; dst = rb; val = va - imm; end
         1:  begin cycles = 4; wr = 1'b1; dst = int'(w[4:0]); val = va + vb; end
         2:  begin cycles = 4; wr = 1'b1; dst = int'(w[4:0]); val = va - vb; end
         20: begin cycles = 3; store = 1'b1; sa = va + imm; so = vb; end
         default: cycles = 2;
      endcase
      instruction = w;
      for (int k = 0; k < cycles; k++) begin
         if (store && k == 2) begin
            check("sw_rw", 32'(rw), 32'd1);
            check("sw_addr", addr, sa);
            check("sw_out", out, so);
         end else begin
            check("idle_rw", 32'(rw), 32'd0);
            check("hold_addr", addr, m_addr);
            check("hold_out", out, m_out);
         end
         tick();
      end
      if (store) begin m_addr = sa; m_out = so; end
      if (wr && dst != 0) m_reg[dst] = val;
      check("end_state_fetch", 32'(dut.c.state), 32'd0);
   endtask

   // Read every register back through the store port (SW with base r0).
   task automatic dump;
      for (int k = 1; k < 32; k++) run(word(20, 0, k, k));
   endtask

   task automatic random_op;
      int sel = int'($urandom_range(0, 6));
      int ra  = int'($urandom_range(0, 31));
      int rb  = int'($urandom_range(0, 31));
      int imm = int'($urandom_range(0, 65535));
      int nop_ops [6] = '{0, 3, 5, 30, 40, 62};
      case (sel)
         0: run(word(1, ra, rb, imm));
         1: run(word(2, ra, rb, imm));
         2: run(word(10, ra, rb, imm));
         3: run(word(11, ra, rb, imm));
         4: run(word(12, ra, rb, imm));
         5: run(word(20, ra, rb, imm));
         default: run(word(nop_ops[$urandom_range(0, 5)], ra, rb, imm));
      endcase
   endtask

   initial begin
      do_reset();
      check("rst_state", 32'(dut.c.state), 32'd0);
      check("rst_sys_dne", 32'(sys_dne), 32'd0);
      check("rst_rw", 32'(rw), 32'd0);
      check("rst_addr", addr, 32'd0);
      check("rst_out", out, 32'd0);
      dump();

      do_reset();
      run(32'h28C00241);
      check("s1_r6", dut.r6.internal, 32'd577);
      check("s1_state", 32'(dut.c.state), 32'd0);
      run(32'h2CC60198);
      check("s2_r6", dut.r6.internal, 32'd985);
      check("s2_r9", dut.r9.internal, 32'd0);
      run(32'h30C90185);
      check("s3_r6", dut.r6.internal, 32'd985);
      check("s3_r9", dut.r9.internal, 32'd596);
      run(word(20, 6, 9, 4));
      check("s5_addr", addr, 32'd989);
      check("s5_out", out, 32'd596);

      run(word(10, 6, 0, 16'h7FFF));
      run(word(11, 6, 6, 1));
      check("s4_r6", dut.r6.internal, 32'h0000_8000);
      run(word(10, 1, 0, 16'hFFFF));
      check("s4_r1_sext", dut.r1.internal, 32'hFFFF_FFFF);
      run(word(11, 1, 1, 1));
      check("s4_r1_wrap", dut.r1.internal, 32'd0);
      run(word(10, 0, 0, 16'h1234));
      run(word(20, 0, 0, 0));
      check("r0_discard", out, 32'd0);

      for (int n = 0; n < 80; n++) random_op();
      dump();

      instruction = word(63, 0, 0, 0);
      tick();
      tick();
      for (int n = 0; n < 5; n++) begin
         check("halt_sys_dne", 32'(sys_dne), 32'd1);
         check("halt_state", 32'(dut.c.state), 32'd4);
         check("halt_rw", 32'(rw), 32'd0);
         instruction = word(10, 3, 0, 99);
         tick();
      end
      check("halt_no_write", dut.r3.internal, m_reg[3]);
      do_reset();
      check("unhalt_state", 32'(dut.c.state), 32'd0);
      check("unhalt_sys_dne", 32'(sys_dne), 32'd0);

      run(word(10, 2, 0, 5));
      instruction = word(11, 2, 7, 7);
      tick();
      tick();
      tick();
      do_reset();
      check("s6_r7", dut.r7.internal, 32'd0);
      check("s6_r2", dut.r2.internal, 32'd0);
      check("s6_state", 32'(dut.c.state), 32'd0);
      check("s6_sys_dne", 32'(sys_dne), 32'd0);
      check("s6_addr", addr, 32'd0);
      dump();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/processor.md
PROCESSOR -- requirements
Module: processor

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 and the register file at 32 entries.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instruction  input  [31:0]  instruction word; sampled only in FETCH.
REQ-006 addr  output  [31:0]  memory address for a store.
REQ-007 out  output  [31:0]  store data.
REQ-008 rw  output  1  1 = memory write this cycle; 0 = idle/read.
REQ-009 sys_dne  output  1  1 = processor halted.

Function
REQ-010 Instruction fields SHALL be: op = [31:26], ra = [25:21], rb = [20:16], imm = [15:0], sign-extended to 32 bits.
REQ-011 All arithmetic SHALL be 32-bit two's complement with wrap-around; there are no flags and no overflow trap.
REQ-012 The controller SHALL have these states, encoded as follows: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3, HALT=4.
REQ-013 FETCH: latch instruction into IR, then go to DECODE.
REQ-014 DECODE: read R[ra] and R[rb] into operand registers A and B, then branch on op as defined in REQ-015 to REQ-020.
REQ-015 op=10 (LI): R[ra] <= imm at the DECODE edge, then FETCH; total 2 clocks.
REQ-016 op=11 (ADDI) and op=12 (SUBI): EXECUTE computes A+imm or A-imm into a result register; WRITEBACK writes the result to R[rb]; then FETCH; total 4 clocks.
REQ-017 op=1 (ADD) and op=2 (SUB): R[imm[4:0]] <= A±B via EXECUTE and WRITEBACK; total 4 clocks.
REQ-018 op=20 (SW): in EXECUTE, drive addr=A+imm, out=B and rw=1 for exactly that cycle; then FETCH; total 3 clocks.
REQ-019 op=63 (HALT): go to HALT and set sys_dne=1; HALT SHALL be held until reset.
REQ-020 Any other op SHALL act as a NOP: DECODE goes to FETCH with no register write.
REQ-021 R0 SHALL read as zero, and writes to R0 SHALL be discarded.
REQ-022 Registers without a write since reset or power-up SHALL hold their prior value; no implicit initialisation.
REQ-023 A write to the register being read by the same instruction (e.g. ADDI r6,r6) SHALL use the old value, because operands are captured in DECODE.
REQ-024 rw SHALL be 0 in every state except EXECUTE of SW.
REQ-025 addr and out SHALL hold their last values when rw=0.

Reset
REQ-026 When reset=1 at a rising edge, the controller SHALL enter FETCH.
REQ-027 Reset SHALL clear IR, A, B, the result register and R0–R31 to 0, and SHALL force addr=0, out=0, rw=0 and sys_dne=0.
REQ-028 Reset SHALL take priority over any in-flight instruction; a partial instruction SHALL write nothing.
REQ-029 Reset SHALL also exit the HALT state.

Structure
REQ-030 Opcode constants and state encodings SHALL reside in a shared package, processor_pkg.
REQ-031 Each register SHALL be an instance of the sub-module reg32, with ports clk, reset, we, d, q and storage named internal.
REQ-032 reg32 instances SHALL be named r0..r31.
REQ-033 The controller instance SHALL be named c, with its state register named state.

Verification
REQ-034 Scenario 1: reset, then instruction=0x28C00241 for 2 clocks -> r6.internal=577, c.state=FETCH.
REQ-035 Scenario 2: then 0x2CC60198 (ADDI r6+408->r6) for 4 clocks -> r6=985; r9 unchanged.
REQ-036 Scenario 3: then 0x30C90185 (SUBI r6-389->r9) for 4 clocks -> r6=985, r9=596.
REQ-037 Scenario 4: LI r6=0x7FFF, then ADDI r6+1 into r6 -> 0x00008000; LI r1=0xFFFF gives r1=0xFFFFFFFF, and ADDI r1+1 gives r1=0, showing wrap-around.
REQ-038 Scenario 5: SW with r6=985, r9=596, imm=4 -> for exactly one cycle rw=1, addr=989, out=596; rw=0 otherwise.
REQ-039 Scenario 6: HALT -> sys_dne=1 held over 5 clocks; reset mid-ADDI -> target register stays 0, state=FETCH, sys_dne=0.
